// File: rtl/ln_share_scheduler_if.sv
// Bundle of the lane request/response and shared ln datapath signals of ln_share_scheduler.
// The scheduler connects through the slave modport; the surrounding lanes and datapath use master.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif

interface ln_share_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = `OUTPUT_BUF_DATASIZE
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      dp_valid;
  logic [DATA_W-1:0]         dp_data;
  logic [DATA_W-1:0]         dp_result;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_data;
  logic [NUM_REQ-1:0]        rsp_err;
  logic [NUM_REQ-1:0]        rsp_ready;

  modport slave (
    input  req_valid, req_data, dp_result, rsp_ready,
    output req_ready, dp_valid, dp_data, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_data, dp_result, rsp_ready,
    input  req_ready, dp_valid, dp_data, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ln_share_scheduler.sv
// Round-robin sharing of one fixed-latency ln datapath among NUM_REQ softmax lanes.
// Define LN_SCHED_PERF_EN to build the saturating issue/stall performance counters.
`ifndef OUTPUT_BUF_DATASIZE
`define OUTPUT_BUF_DATASIZE 32
`endif

module ln_share_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = `OUTPUT_BUF_DATASIZE,
  parameter int PIPE_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  ln_share_scheduler_if.slave  bus,
  output logic                 busy,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic             vld;
    logic [PTR_W-1:0] lane;
    logic             zero;
  } tag_t;

  logic [PTR_W-1:0]   ptr_reg;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  grant_data;
  logic               dp_valid_reg;
  logic [DATA_W-1:0]  dp_data_reg;
  tag_t               tag_pipe_reg [0:PIPE_LAT];
  tag_t               ret_tag;
  logic               tag_any;

  assign eligible = bus.req_valid & ~pending;

  // Rotating priority search starting at ptr_reg; first eligible lane wins.
  always_comb begin
    logic [PTR_W:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) begin
        idx = idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_any && eligible[idx[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
  end

  assign grant_data = bus.req_data[grant_idx*DATA_W +: DATA_W];

  // The tag pipe has one extra stage so its exit lines up with dp_result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      dp_valid_reg <= 1'b0;
      dp_data_reg  <= '0;
      for (int s = 0; s <= PIPE_LAT; s++) begin
        tag_pipe_reg[s] <= '0;
      end
    end else begin
      if (grant_any) begin
        ptr_reg     <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        dp_data_reg <= grant_data;
      end
      dp_valid_reg    <= grant_any;
      tag_pipe_reg[0] <= '{vld: grant_any, lane: grant_idx, zero: (grant_data == '0)};
      for (int s = 1; s <= PIPE_LAT; s++) begin
        tag_pipe_reg[s] <= tag_pipe_reg[s-1];
      end
    end
  end

  assign ret_tag = tag_pipe_reg[PIPE_LAT];

  always_comb begin
    tag_any = 1'b0;
    for (int s = 0; s <= PIPE_LAT; s++) begin
      tag_any = tag_any | tag_pipe_reg[s].vld;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      logic              pending_reg;
      logic              rsp_valid_reg;
      logic              rsp_err_reg;
      logic [DATA_W-1:0] rsp_data_reg;
      logic              ret_hit;
      logic              rsp_fire;

      assign grant[gi] = grant_any && !rst && (grant_idx == PTR_W'(gi));
      assign ret_hit   = ret_tag.vld && (ret_tag.lane == PTR_W'(gi));
      assign rsp_fire  = rsp_valid_reg && bus.rsp_ready[gi];

      // pending blocks a re-grant until the response has been taken, so the buffer cannot overflow.
      always_ff @(posedge clk) begin
        if (rst) begin
          pending_reg   <= 1'b0;
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_data_reg  <= '0;
        end else begin
          if (grant[gi]) begin
            pending_reg <= 1'b1;
          end else if (rsp_fire) begin
            pending_reg <= 1'b0;
          end
          if (ret_hit) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= ret_tag.zero;
            rsp_data_reg  <= ret_tag.zero ? '0 : bus.dp_result;
          end else if (rsp_fire) begin
            rsp_valid_reg <= 1'b0;
          end
        end
      end

      assign pending[gi]                         = pending_reg;
      assign bus.rsp_valid[gi]                   = rsp_valid_reg;
      assign bus.rsp_err[gi]                     = rsp_err_reg;
      assign bus.rsp_data[gi*DATA_W +: DATA_W]   = rsp_data_reg;
    end
  endgenerate

  assign bus.req_ready = grant;
  assign bus.dp_valid  = dp_valid_reg;
  assign bus.dp_data   = dp_data_reg;
  assign busy          = (|pending) | tag_any | dp_valid_reg;

`ifdef LN_SCHED_PERF_EN
  logic [31:0] perf_issue_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (grant_any && (perf_issue_reg != 32'hFFFF_FFFF)) begin
        perf_issue_reg <= perf_issue_reg + 32'd1;
      end
      if ((|(bus.req_valid & ~grant)) && (perf_stall_reg != 32'hFFFF_FFFF)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = perf_issue_reg;
  assign perf_stall_cnt = perf_stall_reg;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ln_share_scheduler.sv
// Directed bench for ln_share_scheduler: a stub datapath returns ~operand PIPE_LAT cycles after issue.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_ln_share_scheduler;
  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 32;
  localparam int PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] stub [0:PIPE_LAT-1];
  int          checks = 0;
  int          errors = 0;

  ln_share_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  ln_share_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .busy           (busy),
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in ln datapath: result is ~operand, garbage in cycles without a matching issue.
  always @(posedge clk) begin
    stub[0] <= bus.dp_valid ? ~bus.dp_data : 32'hBADC_0DE0;
    for (int s = 1; s < PIPE_LAT; s++) stub[s] <= stub[s-1];
  end
  assign bus.dp_result = stub[PIPE_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] d);
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  function automatic logic [31:0] rsp_lane(input int i);
    return bus.rsp_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 4'hF;
    bus.req_data  = '0;
    bus.rsp_ready = 4'h0;

    // Reset held two cycles with all lanes requesting.
    step(); step();
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'h0);
    chk("reset dp_valid", 32'(bus.dp_valid), 32'h0);
    chk("reset dp_data", bus.dp_data, 32'h0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset perf_issue", perf_issue_cnt, 32'h0);
    chk("reset perf_stall", perf_stall_cnt, 32'h0);
    bus.req_valid = 4'h0;
    rst = 1'b0;
    step();

    // Single lane: grant, issue next cycle, response PIPE_LAT+2 after grant.
    step();
    bus.req_valid = 4'b0001;
    set_lane(0, 32'h0001_0000);
    #1;
    $display("single: grant cycle req_ready=%b", bus.req_ready);
    chk("single grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("single dp_valid", 32'(bus.dp_valid), 32'h1);
    chk("single dp_data", bus.dp_data, 32'h0001_0000);
    chk("single busy", 32'(busy), 32'h1);
    step(); #1;
    chk("single dp_valid pulse", 32'(bus.dp_valid), 32'h0);
    step(); step(); #1;
    chk("single rsp early", 32'(bus.rsp_valid), 32'h0);
    step(); #1;
    $display("single: rsp_valid=%b data=%08h", bus.rsp_valid, rsp_lane(0));
    chk("single rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single rsp_data", rsp_lane(0), 32'hFFFE_FFFF);
    chk("single rsp_err", 32'(bus.rsp_err), 32'h0);
    step(); #1;
    chk("single hold", rsp_lane(0), 32'hFFFE_FFFF);
    bus.rsp_ready = 4'b0001;
    #1;
    chk("single busy at handshake", 32'(busy), 32'h1);
    step();
    bus.rsp_ready = 4'b0000;
    #1;
    chk("single rsp cleared", 32'(bus.rsp_valid), 32'h0);
    chk("single idle", 32'(busy), 32'h0);

    // All four lanes: grants 0..3 on consecutive cycles, responses 5..8.
    reset_pulse();
    set_lane(0, 32'h11); set_lane(1, 32'h22); set_lane(2, 32'h33); set_lane(3, 32'h44);
    bus.req_valid = 4'hF;
    #1;
    chk("all c0 grant", 32'(bus.req_ready), 32'h1);
    for (int c = 1; c <= 8; c++) begin
      step(); #1;
      $display("all: cycle %0d req_ready=%b dp_valid=%b rsp_valid=%b", c, bus.req_ready, bus.dp_valid, bus.rsp_valid);
      chk($sformatf("all c%0d grant", c), 32'(bus.req_ready), (c < 4) ? (32'h1 << c) : 32'h0);
      chk($sformatf("all c%0d dp_valid", c), 32'(bus.dp_valid), (c <= 4) ? 32'h1 : 32'h0);
      if (c <= 4) chk($sformatf("all c%0d dp_data", c), bus.dp_data, 32'h11 * c);
      chk($sformatf("all c%0d rsp_valid", c), 32'(bus.rsp_valid), (c >= 5) ? ((32'h1 << (c - 4)) - 1) : 32'h0);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("all rsp_data%0d", i), rsp_lane(i), ~(32'h11 * (i + 1)));
    bus.req_valid = 4'h0;
    bus.rsp_ready = 4'hF;
    step();
    bus.rsp_ready = 4'h0;
    #1;
    chk("all drained", 32'(bus.rsp_valid), 32'h0);
    chk("all idle", 32'(busy), 32'h0);

    // Zero operand on lane 2, then a same-cycle handshake + new request.
    bus.req_valid = 4'b0100;
    set_lane(2, 32'h0);
    #1;
    chk("zero grant", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = 4'b0000;
    #1;
    chk("zero dp_data", bus.dp_data, 32'h0);
    step(); step(); step(); step(); #1;
    $display("zero: rsp_valid=%b data=%08h err=%b", bus.rsp_valid, rsp_lane(2), bus.rsp_err);
    chk("zero rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("zero rsp_data", rsp_lane(2), 32'h0);
    chk("zero rsp_err", 32'(bus.rsp_err), 32'h4);
    bus.rsp_ready = 4'b0100;
    bus.req_valid = 4'b0100;
    set_lane(2, 32'h5);
    #1;
    chk("zero no grant at handshake", 32'(bus.req_ready), 32'h0);
    step();
    bus.rsp_ready = 4'b0000;
    #1;
    chk("zero regrant", 32'(bus.req_ready), 32'h4);
    chk("zero rsp cleared", 32'(bus.rsp_valid), 32'h0);
    step();
    bus.req_valid = 4'b0000;
    step(); step(); step(); step(); #1;
    chk("nonzero rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("nonzero rsp_data", rsp_lane(2), 32'hFFFF_FFFA);
    chk("nonzero rsp_err", 32'(bus.rsp_err), 32'h0);
    bus.rsp_ready = 4'b0100;
    step();
    bus.rsp_ready = 4'b0000;

    // Fairness: lanes 1 and 3, rsp_ready tied high -> 1,3 grants every 6 cycles.
    reset_pulse();
    set_lane(1, 32'h100); set_lane(3, 32'h300);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 4'hF;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) step();
      #1;
      $display("fair: cycle %0d req_ready=%b", c, bus.req_ready);
      chk($sformatf("fair c%0d grant", c), 32'(bus.req_ready),
          (c % 6 == 0) ? 32'h2 : (c % 6 == 1) ? 32'h8 : 32'h0);
    end
`ifdef LN_SCHED_PERF_EN
    chk("fair perf_issue", perf_issue_cnt, 32'd6);
    chk("fair perf_stall", perf_stall_cnt, 32'd17);
`endif
    bus.req_valid = 4'h0;
    for (int c = 0; c < 8; c++) step();
    bus.rsp_ready = 4'h0;
    #1;
    chk("fair idle", 32'(busy), 32'h0);

    // Backpressure: lane 0 response held 20 cycles while lane 0 keeps requesting.
    reset_pulse();
    set_lane(0, 32'h1234);
    bus.req_valid = 4'b0001;
    #1;
    chk("bp grant", 32'(bus.req_ready), 32'h1);
    for (int c = 1; c <= 5; c++) step();
    #1;
    chk("bp rsp_valid", 32'(bus.rsp_valid), 32'h1);
    for (int c = 6; c <= 25; c++) begin
      step(); #1;
      chk($sformatf("bp c%0d no regrant", c), 32'(bus.req_ready), 32'h0);
      chk($sformatf("bp c%0d hold", c), rsp_lane(0), 32'hFFFF_EDCB);
    end
    step();
    bus.rsp_ready = 4'b0001;
    #1;
    $display("bp: handshake cycle req_ready=%b rsp_valid=%b", bus.req_ready, bus.rsp_valid);
    chk("bp no grant at handshake", 32'(bus.req_ready), 32'h0);
`ifdef LN_SCHED_PERF_EN
    chk("bp perf_issue", perf_issue_cnt, 32'd1);
    chk("bp perf_stall", perf_stall_cnt, 32'd25);
`endif
    step();
    bus.rsp_ready = 4'b0000;
    #1;
    chk("bp rsp cleared", 32'(bus.rsp_valid), 32'h0);
    chk("bp regrant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'h0;
    bus.rsp_ready = 4'hF;
    for (int c = 0; c < 8; c++) step();
    bus.rsp_ready = 4'h0;

    // Reset one cycle after two grants: stale results must not surface.
    reset_pulse();
    bus.req_valid = 4'b0011;
    #1;
    chk("rst c0 grant", 32'(bus.req_ready), 32'h1);
    step(); #1;
    chk("rst c1 grant", 32'(bus.req_ready), 32'h2);
    step();
    rst = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    chk("rst no grant in reset", 32'(bus.req_ready), 32'h0);
    chk("rst dp_valid before", 32'(bus.dp_valid), 32'h1);
    step();
    rst = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    chk("rst dp_valid", 32'(bus.dp_valid), 32'h0);
    chk("rst dp_data", bus.dp_data, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
`ifdef LN_SCHED_PERF_EN
    chk("rst perf_issue", perf_issue_cnt, 32'h0);
`endif
    for (int c = 0; c < 8; c++) begin
      step(); #1;
      chk($sformatf("rst stale c%0d rsp_valid", c), 32'(bus.rsp_valid), 32'h0);
      chk($sformatf("rst stale c%0d busy", c), 32'(busy), 32'h0);
    end
    bus.req_valid = 4'b1010;
    #1;
    $display("rst: post-reset grant req_ready=%b", bus.req_ready);
    chk("rst ptr zero", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = 4'h0;
    bus.rsp_ready = 4'hF;
    for (int c = 0; c < 8; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ln_share_scheduler.md
Name: ln_share_scheduler

Overview:
- Round-robin scheduler that shares one fixed-latency ln datapath among NUM_REQ softmax lanes.
- The shared datapath is a leading-one detect, normalise, LUT and combine chain.
- Accepts one operand per cycle from at most one lane and issues it to the datapath with a tag; the tag travels alongside.
- Steers each returning result into the owning lane's one-entry response buffer.
- Sits between the softmax row-sum stage and the ln datapath.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- DATA_W, `OUTPUT_BUF_DATASIZE, operand/result width (fixed point).
- PIPE_LAT, 3, cycles from dp_valid/dp_data to dp_result being valid (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-lane operand valid
- req_data  in  NUM_REQ*DATA_W  per-lane operand; lane i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; the handshake completes when req_valid[i] & req_ready[i]
- dp_valid  out  1  operand issued to the datapath (registered)
- dp_data  out  DATA_W  operand to the datapath (registered)
- dp_result  in  DATA_W  datapath result, valid exactly PIPE_LAT cycles after the dp_valid cycle
- rsp_valid  out  NUM_REQ  per-lane result valid
- rsp_data  out  NUM_REQ*DATA_W  per-lane result
- rsp_err  out  NUM_REQ  result came from a zero operand (ln undefined)
- rsp_ready  in  NUM_REQ  per-lane result accept
- busy  out  1  any lane pending or any issue in flight
- perf_issue_cnt  out  32  issued-operation count (optional feature)
- perf_stall_cnt  out  32  stall-cycle count (optional feature)

Behaviour:
- Reset:
  - All of these clear to 0: req_ready, dp_valid, dp_data, rsp_valid, rsp_data, rsp_err, busy, pending[], tag pipe, perf counters.
  - RR pointer resets to 0.
  - Reset asserted mid-operation discards all in-flight tags. A dp_result that arrives after reset is ignored.
- Eligibility: eligible[i] = req_valid[i] & ~pending[i].
  - pending[i] sets on lane i's grant.
  - pending[i] clears on the rsp_valid[i] & rsp_ready[i] handshake.
  - Rule: one outstanding op per lane.
- Arbitration (combinational):
  - Search starts at ptr and proceeds ptr, ptr+1, … mod NUM_REQ. The first eligible lane gets req_ready.
  - On grant of lane g, ptr <= (g+1) mod NUM_REQ. With no grant, ptr holds.
- Issue:
  - Grant in cycle t -> dp_valid=1 and dp_data=req_data[g] in cycle t+1.
  - In the same cycle t+1, tag {g, zero=(operand==0)} enters stage 0 of a PIPE_LAT-deep tag shift register.
  - dp_valid is high for exactly one cycle per grant. Back-to-back grants give dp_valid high continuously.
- Return:
  - In cycle t+1+PIPE_LAT, the tag exits with valid. Register rsp_data[g] <= zero ? 0 : dp_result and rsp_err[g] <= zero.
  - rsp_valid[g] = 1 from cycle t+2+PIPE_LAT.
  - Total latency, grant to rsp_valid: PIPE_LAT+2 cycles.
- Response hold: rsp_valid/rsp_data/rsp_err hold until rsp_ready[g]. The handshake clears rsp_valid[g] and pending[g] next cycle.
  - The buffer cannot overflow, because pending blocks a re-grant.
  - The earliest re-grant of the same lane is the cycle after the handshake.
- Simultaneous events:
  - Return to lane A and grant to lane B in the same cycle are independent.
  - Handshake on lane i and a new req_valid[i] in the same cycle: no grant in that cycle (pending still 1); grant is possible the next cycle.
- busy = |pending | (any tag-pipe stage valid) | dp_valid.

Optional Feature:
- Macro: LN_SCHED_PERF_EN.
- Defined:
  - perf_issue_cnt increments on every grant.
  - perf_stall_cnt increments on every cycle with (|(req_valid & ~req_ready)).
  - Both saturate at 0xFFFFFFFF and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Single lane: rst 2 cycles, lane 0 req 0x0001_0000 at cycle 5 -> dp_valid at 6, rsp_valid[0] at 10 with rsp_data = dp_result from cycle 9, rsp_err=0, busy high from 5 through the handshake.
- All 4 lanes valid from cycle 0 after reset -> grants in order 0,1,2,3 on consecutive cycles, dp_valid high 4 cycles, responses on lanes 0..3 at cycles 5..8.
- Fairness: lanes 1 and 3 continuously valid, rsp_ready tied 1 -> grants alternate 1,3,1,3; no lane waits more than NUM_REQ eligible cycles.
- Zero operand: lane 2 req_data=0 -> issued normally, rsp_data[2]=0, rsp_err[2]=1; the next nonzero op on lane 2 returns rsp_err=0.
- Backpressure: lane 0 rsp_ready=0 for 20 cycles while req_valid[0]=1 -> no re-grant, rsp_data held stable. Release rsp_ready -> re-grant the cycle after the handshake. With LN_SCHED_PERF_EN, perf_stall_cnt grows by 20+.
- Reset mid-flight: assert rst one cycle after two grants -> all outputs 0 next cycle, no rsp_valid produced from the stale dp_result, ptr=0.
